// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the packet bank scheduler
package eth_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_PARSING
  } bank_status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KICK,
    ST_PARSE,
    ST_HANDOFF
  } sched_state_t;

  localparam int ADDR_W            = 9;
  localparam int PARSE_TIMEOUT_DEF = 1024;

  // Lowest-index empty bank; caller only uses it when some bank is empty.
  function automatic logic lowest_empty(input bank_status_t s0);
    return (s0 == BANK_EMPTY) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/bank_tracker.sv
// rtl/bank_tracker.sv - per-bank status, receiver grant/overflow and FULL-bank age order
module bank_tracker
  import eth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_req,
  input  logic rx_done,
  input  logic pop,
  input  logic rel,
  input  logic rel_bank,
  output logic rx_grant,
  output logic rx_bank,
  output logic rx_overflow,
  output logic ovf_evt,
  output logic full_avail,
  output logic oldest_bank
);

  bank_status_t [1:0] status;
  logic [1:0] age_q;
  logic [1:0] age_cnt;
  logic [1:0] nq;
  logic [1:0] ncnt;
  logic       any_filling;
  logic       any_empty;
  logic       grant_ok;
  logic       grant_idx;
  logic       done_ok;
  logic       pop_ok;

  always_comb begin
    any_filling = (status[0] == BANK_FILLING) || (status[1] == BANK_FILLING);
    any_empty   = (status[0] == BANK_EMPTY) || (status[1] == BANK_EMPTY);
    grant_idx   = lowest_empty(status[0]);
    grant_ok    = rx_req && !any_filling && any_empty;
    ovf_evt     = rx_req && !grant_ok;
    done_ok     = rx_done && any_filling;
    full_avail  = (age_cnt != 2'd0);
    oldest_bank = age_q[0];
    pop_ok      = pop && full_avail;

    // Pop first, then append, so a same-cycle pop and push keep age order.
    nq   = age_q;
    ncnt = age_cnt;
    if (pop_ok) begin
      nq[0] = age_q[1];
      ncnt  = age_cnt - 2'd1;
    end
    if (done_ok) begin
      nq[ncnt[0]] = rx_bank;
      ncnt        = ncnt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status[0]   <= BANK_EMPTY;
      status[1]   <= BANK_EMPTY;
      age_q       <= 2'b00;
      age_cnt     <= 2'd0;
      rx_grant    <= 1'b0;
      rx_bank     <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_grant    <= grant_ok;
      rx_overflow <= ovf_evt;
      if (grant_ok) begin
        status[grant_idx] <= BANK_FILLING;
        rx_bank           <= grant_idx;
      end
      // rx_bank names the filling bank until the next grant.
      if (done_ok)
        status[rx_bank] <= BANK_FULL;
      if (pop_ok)
        status[age_q[0]] <= BANK_PARSING;
      if (rel)
        status[rel_bank] <= BANK_EMPTY;
      age_q   <= nq;
      age_cnt <= ncnt;
    end
  end

endmodule

// File: rtl/pkt_bank_sched.sv
// rtl/pkt_bank_sched.sv - two-bank receive scheduler: parser kick, timeout drop, consumer handoff
module pkt_bank_sched
  import eth_pkg::*;
#(
  parameter int PARSE_TIMEOUT = PARSE_TIMEOUT_DEF,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_req,
  input  logic              rx_done,
  output logic              rx_grant,
  output logic              rx_bank,
  output logic              rx_overflow,
  output logic              par_newpacket,
  output logic              par_bank,
  input  logic              par_start_read,
  input  logic [ADDR_W-1:0] par_last_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_last_addr,
  output logic [CNT_W-1:0]  cnt_overflow,
  output logic [CNT_W-1:0]  cnt_drop
);

  localparam int TW = (PARSE_TIMEOUT > 1) ? $clog2(PARSE_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PARSE_TIMEOUT - 1);

  sched_state_t state;
  logic [TW-1:0] tcnt;
  logic pop;
  logic rel;
  logic ovf_evt;
  logic full_avail;
  logic oldest_bank;

  always_comb begin
    pop = (state == ST_IDLE) && full_avail && !out_valid;
    rel = (state == ST_PARSE) && (par_start_read || (tcnt == T_LAST));
  end

  bank_tracker u_bank_tracker (
    .clk         (clk),
    .rst         (rst),
    .rx_req      (rx_req),
    .rx_done     (rx_done),
    .pop         (pop),
    .rel         (rel),
    .rel_bank    (par_bank),
    .rx_grant    (rx_grant),
    .rx_bank     (rx_bank),
    .rx_overflow (rx_overflow),
    .ovf_evt     (ovf_evt),
    .full_avail  (full_avail),
    .oldest_bank (oldest_bank)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      tcnt          <= '0;
      par_newpacket <= 1'b0;
      par_bank      <= 1'b0;
      out_valid     <= 1'b0;
      out_last_addr <= '0;
      cnt_overflow  <= '0;
      cnt_drop      <= '0;
    end else begin
      par_newpacket <= 1'b0;
      if (ovf_evt && (cnt_overflow != '1))
        cnt_overflow <= cnt_overflow + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (pop) begin
            par_bank      <= oldest_bank;
            par_newpacket <= 1'b1;
            state         <= ST_KICK;
          end
        end
        ST_KICK: begin
          tcnt  <= '0;
          state <= ST_PARSE;
        end
        ST_PARSE: begin
          // A start_read landing on the timeout cycle still wins.
          if (par_start_read) begin
            out_last_addr <= par_last_addr;
            out_valid     <= 1'b1;
            state         <= ST_HANDOFF;
          end else if (tcnt == T_LAST) begin
            if (cnt_drop != '1)
              cnt_drop <= cnt_drop + CNT_W'(1);
            state <= ST_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_HANDOFF: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_bank_sched.sv
// tb/tb_pkt_bank_sched.sv - scoreboard bench for pkt_bank_sched
module tb_pkt_bank_sched;
  localparam int PT = 16;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_req = 1'b0;
  logic       rx_done = 1'b0;
  logic       rx_grant;
  logic       rx_bank;
  logic       rx_overflow;
  logic       par_newpacket;
  logic       par_bank;
  logic       par_start_read = 1'b0;
  logic [8:0] par_last_addr = 9'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_last_addr;
  logic [CW-1:0] cnt_overflow;
  logic [CW-1:0] cnt_drop;

  int total = 0;
  int bad = 0;
  logic       exp_bank_q[$];
  logic [8:0] exp_addr_q[$];

  always #5 clk = ~clk;

  pkt_bank_sched #(.PARSE_TIMEOUT(PT), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_req         (rx_req),
    .rx_done        (rx_done),
    .rx_grant       (rx_grant),
    .rx_bank        (rx_bank),
    .rx_overflow    (rx_overflow),
    .par_newpacket  (par_newpacket),
    .par_bank       (par_bank),
    .par_start_read (par_start_read),
    .par_last_addr  (par_last_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last_addr  (out_last_addr),
    .cnt_overflow   (cnt_overflow),
    .cnt_drop       (cnt_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx_req = 1'b0;
    rx_done = 1'b0;
    par_start_read = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_bank_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic pulse_req();
    rx_req = 1'b1;
    tick();
    rx_req = 1'b0;
  endtask

  task automatic pulse_done(input logic b);
    rx_done = 1'b1;
    exp_bank_q.push_back(b);
    tick();
    rx_done = 1'b0;
  endtask

  task automatic start_read(input logic [8:0] a);
    par_start_read = 1'b1;
    par_last_addr = a;
    exp_addr_q.push_back(a);
    tick();
    par_start_read = 1'b0;
  endtask

  task automatic wait_np(input int lim, output bit found);
    found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      tick();
      if (par_newpacket === 1'b1) found = 1'b1;
    end
  endtask

  function automatic logic pop_bank();
    return (exp_bank_q.size() != 0) ? exp_bank_q.pop_front() : 1'bx;
  endfunction

  function automatic logic [8:0] pop_addr();
    return (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 9'hxxx;
  endfunction

  task automatic test_reset();
    logic [20:0] outs;
    rst = 1'b1;
    tick();
    outs = {rx_grant, rx_bank, rx_overflow, par_newpacket, par_bank, out_valid,
            out_last_addr, cnt_overflow, cnt_drop};
    total++;
    if (outs !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    tick();
    start_read(9'd5);
    void'(exp_addr_q.pop_back());
    tick();
    total++;
    if ({out_valid, par_newpacket} !== 2'b00) begin
      bad++;
      $display("FAIL idle_start_read_ignored: got %b expected 00", {out_valid, par_newpacket});
    end
  endtask

  task automatic test_single();
    bit found;
    logic eb;
    logic [8:0] ea;
    apply_reset();
    out_ready = 1'b1;
    pulse_req();
    total++;
    if ({rx_grant, rx_bank} !== 2'b10) begin
      bad++;
      $display("FAIL single_grant: got %b expected 10", {rx_grant, rx_bank});
    end
    repeat (49) tick();
    pulse_done(1'b0);
    wait_np(3, found);
    eb = pop_bank();
    total++;
    if (!found || par_bank !== eb) begin
      bad++;
      $display("FAIL single_newpacket: found=%0d bank=%b expected bank %b", found, par_bank, eb);
    end
    tick();
    start_read(9'd100);
    ea = pop_addr();
    total++;
    if (out_valid !== 1'b1 || out_last_addr !== ea) begin
      bad++;
      $display("FAIL single_handoff: valid=%b addr=%0d expected 1/%0d", out_valid, out_last_addr, ea);
    end
    tick();
    total++;
    if ({out_valid, cnt_drop, cnt_overflow} !== 7'd0) begin
      bad++;
      $display("FAIL single_after_accept: got %b expected 0", {out_valid, cnt_drop, cnt_overflow});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_order_overflow();
    bit found;
    logic eb;
    logic [8:0] ea;
    apply_reset();
    pulse_req();
    total++;
    if ({rx_grant, rx_bank} !== 2'b10) begin
      bad++;
      $display("FAIL order_grant0: got %b expected 10", {rx_grant, rx_bank});
    end
    tick();
    pulse_done(1'b0);
    wait_np(3, found);
    eb = pop_bank();
    total++;
    if (!found || par_bank !== eb) begin
      bad++;
      $display("FAIL order_first_bank: found=%0d bank=%b expected %b", found, par_bank, eb);
    end
    pulse_req();
    total++;
    if ({rx_grant, rx_bank} !== 2'b11) begin
      bad++;
      $display("FAIL order_grant1: got %b expected 11", {rx_grant, rx_bank});
    end
    pulse_done(1'b1);
    pulse_req();
    total++;
    if ({rx_overflow, rx_grant, cnt_overflow} !== {2'b10, 3'd1}) begin
      bad++;
      $display("FAIL order_overflow: got %b expected 10001", {rx_overflow, rx_grant, cnt_overflow});
    end
    start_read(9'd299);
    ea = pop_addr();
    for (int i = 0; i < 20; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_last_addr !== ea || par_newpacket !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: valid=%b addr=%0d np=%b expected 1/%0d/0",
                 i, out_valid, out_last_addr, par_newpacket, ea);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, par_newpacket} !== 2'b00) begin
      bad++;
      $display("FAIL gap_idle: got %b expected 00", {out_valid, par_newpacket});
    end
    tick();
    eb = pop_bank();
    total++;
    if (par_newpacket !== 1'b1 || par_bank !== eb) begin
      bad++;
      $display("FAIL gap_kick: np=%b bank=%b expected 1/%b", par_newpacket, par_bank, eb);
    end
    tick();
    start_read(9'd7);
    ea = pop_addr();
    total++;
    if (out_valid !== 1'b1 || out_last_addr !== ea) begin
      bad++;
      $display("FAIL second_handoff: valid=%b addr=%0d expected 1/%0d", out_valid, out_last_addr, ea);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit found;
    logic eb;
    logic [8:0] ea;
    apply_reset();
    pulse_req();
    tick();
    pulse_done(1'b0);
    wait_np(3, found);
    eb = pop_bank();
    total++;
    if (!found || par_bank !== eb) begin
      bad++;
      $display("FAIL to_first_bank: found=%0d bank=%b expected %b", found, par_bank, eb);
    end
    for (int i = 1; i <= 16; i++) begin
      rx_req = (i == 3);
      rx_done = (i == 6);
      if (i == 6) exp_bank_q.push_back(1'b1);
      tick();
      if (i == 3) begin
        total++;
        if ({rx_grant, rx_bank} !== 2'b11) begin
          bad++;
          $display("FAIL to_grant1: got %b expected 11", {rx_grant, rx_bank});
        end
      end
    end
    rx_req = 1'b0;
    rx_done = 1'b0;
    total++;
    if (cnt_drop !== 3'd0) begin
      bad++;
      $display("FAIL to_before: cnt_drop=%0d expected 0", cnt_drop);
    end
    rx_req = 1'b1;
    tick();
    total++;
    if (cnt_drop !== 3'd1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_drop: cnt_drop=%0d valid=%b expected 1/0", cnt_drop, out_valid);
    end
    tick();
    rx_req = 1'b0;
    eb = pop_bank();
    total++;
    if ({rx_grant, rx_bank} !== 2'b10 || par_newpacket !== 1'b1 || par_bank !== eb) begin
      bad++;
      $display("FAIL to_reuse: grant/bank=%b np=%b par_bank=%b expected 10/1/%b",
               {rx_grant, rx_bank}, par_newpacket, par_bank, eb);
    end
    repeat (16) tick();
    start_read(9'd42);
    ea = pop_addr();
    total++;
    if (out_valid !== 1'b1 || out_last_addr !== ea || cnt_drop !== 3'd1) begin
      bad++;
      $display("FAIL to_coincide: valid=%b addr=%0d drop=%0d expected 1/%0d/1",
               out_valid, out_last_addr, cnt_drop, ea);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    bit seen;
    logic eb;
    logic [20:0] outs;
    apply_reset();
    pulse_req();
    tick();
    pulse_done(1'b0);
    wait_np(3, found);
    eb = pop_bank();
    total++;
    if (!found || par_bank !== eb) begin
      bad++;
      $display("FAIL rm_bank: found=%0d bank=%b expected %b", found, par_bank, eb);
    end
    pulse_req();
    pulse_req();
    total++;
    if (cnt_overflow !== 3'd1) begin
      bad++;
      $display("FAIL rm_pre_ovf: cnt_overflow=%0d expected 1", cnt_overflow);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    outs = {rx_grant, rx_bank, rx_overflow, par_newpacket, par_bank, out_valid,
            out_last_addr, cnt_overflow, cnt_drop};
    total++;
    if (outs !== 21'd0) begin
      bad++;
      $display("FAIL rm_async: got %h expected 0", outs);
    end
    tick();
    tick();
    rst = 1'b0;
    exp_bank_q.delete();
    exp_addr_q.delete();
    pulse_req();
    total++;
    if ({rx_grant, rx_bank} !== 2'b10) begin
      bad++;
      $display("FAIL rm_regrant: got %b expected 10", {rx_grant, rx_bank});
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (par_newpacket !== 1'b0 || cnt_drop !== 3'd0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rm_trailing: got activity expected none");
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_cnt;
    apply_reset();
    pulse_req();
    exp_cnt = '0;
    for (int n = 1; n <= 9; n++) begin
      if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      pulse_req();
      total++;
      if (rx_overflow !== 1'b1 || cnt_overflow !== exp_cnt) begin
        bad++;
        $display("FAIL sat_%0d: ovf=%b cnt=%0d expected 1/%0d", n, rx_overflow, cnt_overflow, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order_overflow();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
